dcache_wb_dm: RTL
=================

Name: dcache_wb_dm

Overview:
- Data-cache responder for the pipeline's D-cache interface: receives addr/ren/wen/wdata from the core and returns rdata/stall.
- Direct-mapped, write-back, write-allocate; 4-word (128-bit) lines.
- Misses are serviced over a line-wide memory port with a ready handshake.
- Sits between the core's DCACHE_* pins and the backing memory model/controller.

Parameters:
- INDEX_W, 3, log2 of line count (default 8 lines).
- ADDR_W, 32, core byte-address width.
- Derived: TAG_W = ADDR_W-4-INDEX_W (default 25); line address width LA_W = ADDR_W-4 (default 28).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- proc_addr  in  ADDR_W  byte address; bits[1:0] ignored, [3:2] word offset, [3+INDEX_W:4] index, upper bits tag.
- proc_ren  in  1  load request.
- proc_wen  in  1  store request.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data.
- proc_stall  out  1  request not complete this cycle; core holds request stable.
- mem_read  out  1  line fill request.
- mem_write  out  1  line writeback request.
- mem_addr  out  LA_W  line address (byte address >>4).
- mem_wdata  out  128  victim line; word0 in [31:0].
- mem_rdata  in  128  fill line; word0 in [31:0].
- mem_ready  in  1  one-cycle completion pulse for current mem_read/mem_write.

Behaviour:
- Storage per line: valid, dirty, tag, 4x32 data.
- Reset: all valid=0, dirty=0, state=IDLE, mem_read=0, mem_write=0, proc_rdata=0. Data/tag arrays need no reset.
- req = proc_ren|proc_wen.
- hit = valid[idx] & (tag[idx]==addr tag).
- If proc_ren and proc_wen are both high, wen has priority and the access is treated as a store.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - proc_stall = req & ~hit (combinational).
  - Read hit: proc_rdata = selected word in the same cycle, stall=0; zero-latency hit.
  - Write hit: word written at the clock edge, dirty[idx]=1, stall=0.
  - Miss with valid & dirty victim -> WRITEBACK. Otherwise -> ALLOCATE.
  - No request: stall=0, no state change. proc_rdata is don't-care but must not be X after reset.
- WRITEBACK:
  - mem_write=1; mem_addr={victim tag, idx}; mem_wdata=victim line; stall=1.
  - All held constant until mem_ready. On mem_ready -> ALLOCATE; dirty cleared.
- ALLOCATE:
  - mem_read=1; mem_addr={req tag, idx}; stall=1.
  - On mem_ready: line<=mem_rdata, tag<=req tag, valid=1, dirty=0 -> IDLE.
  - Next cycle the held request hits and completes in IDLE (a store then sets dirty).
- mem_read and mem_write are never both high. mem_ready is ignored in IDLE.
- Miss latency with memory ready latency L cycles:
  - Clean: L+1 stall cycles before completion.
  - Dirty: 2L+1 stall cycles.
- Request dropped mid-miss (core flush): the FSM completes the current transaction anyway. The line is filled; no corruption.
- Reset asserted mid-miss: returns to IDLE immediately, mem_read/mem_write deassert asynchronously, all lines invalid.
- Index wrap: addresses differing only in tag map to the same line and conflict-evict. No associativity.
- proc_addr[1:0] is never checked; no misalignment error.

Test Plan:
- Reset, then load 0x00000010 with memory returning line {0x44,0x33,0x22,0x11} after 3 cycles -> mem_read with mem_addr=0x0000001, stall for 4 cycles, then proc_rdata=0x11 with stall=0.
- Store 0xDEADBEEF to 0x00000014 right after that fill -> no stall, no memory traffic. Subsequent load of 0x14 returns 0xDEADBEEF in the same cycle.
- Load 0x00000090 (same index 1, different tag) -> mem_write first with mem_addr=0x0000001 and mem_wdata word1=0xDEADBEEF. Then mem_read with mem_addr=0x0000009. Data returned after the second mem_ready.
- proc_ren and proc_wen high together at a hit address -> treated as a store; line dirty; no stall.
- Assert rst low during ALLOCATE with mem_read high -> mem_read drops without waiting for a clock. After release, load of the previously cached address misses again (valid cleared).
- 8 sequential loads of 0x00,0x10,...,0x70 followed by a repeat pass -> exactly 8 fills, the second pass has zero stalls, and no mem_write is issued (all lines clean).

Source files
------------

// File: rtl/dcache_wb_dm_if.sv
// Bus bundle between the core-side D-cache pins, the cache and the backing line memory.
// The master side is the environment (core + memory); the slave side is the cache.
interface dcache_wb_dm_if #(
    parameter int ADDR_W = 32
);
    localparam int LA_W = ADDR_W - 4;

    logic [ADDR_W-1:0] proc_addr;
    logic              proc_ren;
    logic              proc_wen;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;

    logic              mem_read;
    logic              mem_write;
    logic [LA_W-1:0]   mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport master (
        output proc_addr, proc_ren, proc_wen, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  proc_addr, proc_ren, proc_wen, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits complete in the request cycle; misses write back a dirty victim, then fill.
module dcache_wb_dm #(
    parameter int INDEX_W = 3,
    parameter int ADDR_W  = 32
) (
    input logic           clk,
    input logic           rst,
    dcache_wb_dm_if.slave bus
);
    localparam int TAG_W = ADDR_W - 4 - INDEX_W;
    localparam int LA_W  = ADDR_W - 4;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    // Request decode
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_off;
    logic               req;
    logic               hit;
    logic               unused_addr_lsb;

    assign req_idx         = bus.proc_addr[3+INDEX_W:4];
    assign req_tag         = bus.proc_addr[ADDR_W-1:4+INDEX_W];
    assign req_off         = bus.proc_addr[3:2];
    assign req             = bus.proc_ren | bus.proc_wen;
    assign unused_addr_lsb = ^bus.proc_addr[1:0];

    // Line storage
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     line_q [LINES];

    // FSM and registered memory-port outputs
    state_t             state_q, state_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [LA_W-1:0]    mem_addr_q, mem_addr_d;
    logic [127:0]       mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;

    // Array write port
    logic               line_we;
    logic               tag_we;
    logic [INDEX_W-1:0] wr_idx;
    logic [127:0]       line_wdata;

    logic [127:0] cur_line;
    logic [31:0]  rdata;
    logic         stall;

    assign cur_line = line_q[req_idx];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;
        line_we     = 1'b0;
        tag_we      = 1'b0;
        wr_idx      = req_idx;
        line_wdata  = cur_line;
        rdata       = '0;
        stall       = 1'b0;

        case (state_q)
            S_IDLE: begin
                stall = req & ~hit;
                if (hit) begin
                    rdata = cur_line[{req_off, 5'd0} +: 32];
                end
                if (req && hit && bus.proc_wen) begin
                    line_we                            = 1'b1;
                    line_wdata[{req_off, 5'd0} +: 32]  = bus.proc_wdata;
                    dirty_d[req_idx]                   = 1'b1;
                end else if (req && !hit) begin
                    // Latch the miss so a dropped request still completes its fill.
                    miss_tag_d = req_tag;
                    miss_idx_d = req_idx;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d     = S_WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[req_idx], req_idx};
                        mem_wdata_d = cur_line;
                    end else begin
                        state_d    = S_ALLOCATE;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
            end

            S_WRITEBACK: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    dirty_d[miss_idx_q] = 1'b0;
                    mem_write_d         = 1'b0;
                    mem_read_d          = 1'b1;
                    mem_addr_d          = {miss_tag_q, miss_idx_q};
                    state_d             = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    line_we             = 1'b1;
                    tag_we              = 1'b1;
                    wr_idx              = miss_idx_q;
                    line_wdata          = bus.mem_rdata;
                    valid_d[miss_idx_q] = 1'b1;
                    dirty_d[miss_idx_q] = 1'b0;
                    mem_read_d          = 1'b0;
                    state_d             = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
        end
    end

    // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (line_we) line_q[wr_idx] <= line_wdata;
        if (tag_we)  tag_q[wr_idx]  <= miss_tag_q;
    end

    assign bus.proc_rdata = rdata;
    assign bus.proc_stall = stall;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
